// File: rtl/pwm_multi_fade.sv
// rtl/pwm_multi_fade.sv - multi-channel PWM LED driver with debounced mode button and fade engine (option: PWM_FADE_GAMMA_EN)
module pwm_multi_fade #(
    parameter int SYS_CLOCK_FREQ = 50_000_000,
    parameter int CH             = 4,
    parameter int SCALE          = 256,
    parameter int DIV            = 1024,
    parameter int DEB_MSEC       = 20
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          sw_in,
    output logic [CH-1:0] led,
    output logic [1:0]    mode
);
    localparam int W       = $clog2(SCALE);
    localparam int DEB_CYC = SYS_CLOCK_FREQ / 1000 * DEB_MSEC;
    localparam int DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int FW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int STEP    = 2 * SCALE / CH;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_ON      = 2'd1,
        M_BREATHE = 2'd2,
        M_CHASE   = 2'd3
    } mode_t;

    mode_t         mode_q;
    mode_t         mode_nxt;

    logic          s1;
    logic          s2;
    logic          stable;
    logic [DW-1:0] dcnt;
    logic          deb_done;
    logic          press;

    logic [FW-1:0] fcnt;
    logic [W:0]    ph;
    logic          fade_tick;

    logic [W-1:0]  pcnt;
    logic          boundary;
    logic [W:0]    duty      [CH];
    logic [W:0]    duty_next [CH];

    // Triangle wave over one 2*SCALE phase cycle; the falling half is the
    // bitwise complement of the low bits.
    function automatic logic [W-1:0] tri_wave(input logic [W:0] p);
        return p[W] ? ~p[W-1:0] : p[W-1:0];
    endfunction

    // Maps a triangle level to a duty value, optionally through a square-law curve.
    function automatic logic [W:0] shape(input logic [W-1:0] t);
`ifdef PWM_FADE_GAMMA_EN
        logic [2*W-1:0] sq;
        sq = {{W{1'b0}}, t} * {{W{1'b0}}, t};
        return {1'b0, sq[2*W-1:W]};
`else
        return {1'b0, t};
`endif
    endfunction

    // The filter has seen DEB_CYC consecutive disagreeing samples.
    assign deb_done  = (s2 != stable) && (dcnt == DW'(DEB_CYC - 1));
    // Only a 1->0 transition of the filtered level counts as a press.
    assign press     = deb_done && stable;
    assign fade_tick = (fcnt == FW'(DIV - 1));
    assign boundary  = (pcnt == W'(SCALE - 1));
    assign mode      = mode_q;

    // Two-flop synchroniser followed by the debounce counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            stable <= 1'b1;
            dcnt   <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
            if (s2 == stable) begin
                dcnt <= '0;
            end else if (deb_done) begin
                stable <= s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // Mode state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mode_q <= M_OFF;
        end else begin
            mode_q <= mode_nxt;
        end
    end

    // Mode advances cyclically on each accepted press.
    always_comb begin
        mode_nxt = mode_q;
        if (press) begin
            case (mode_q)
                M_OFF:     mode_nxt = M_ON;
                M_ON:      mode_nxt = M_BREATHE;
                M_BREATHE: mode_nxt = M_CHASE;
                M_CHASE:   mode_nxt = M_OFF;
                default:   mode_nxt = M_OFF;
            endcase
        end
    end

    // Fade prescaler and phase; a mode change restarts the fade from phase 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fcnt <= '0;
            ph   <= '0;
        end else if (press) begin
            fcnt <= '0;
            ph   <= '0;
        end else if (fade_tick) begin
            fcnt <= '0;
            ph   <= ph + (W+1)'(1);
        end else begin
            fcnt <= fcnt + FW'(1);
        end
    end

    // Per-channel target duty for the next PWM period, from the current mode.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            duty_next[i] = '0;
            case (mode_q)
                M_OFF:     duty_next[i] = '0;
                M_ON:      duty_next[i] = (W+1)'(SCALE);
                M_BREATHE: duty_next[i] = shape(tri_wave(ph));
                M_CHASE:   duty_next[i] = shape(tri_wave(ph + (W+1)'(i * STEP)));
                default:   duty_next[i] = '0;
            endcase
        end
    end

    // Shared free-running PWM counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + W'(1);
        end
    end

    // Duty is latched only at the period boundary so each period is glitch-free;
    // the comparator output is registered.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < CH; i++) begin
                duty[i] <= '0;
            end
            led <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (boundary) begin
                    duty[i] <= duty_next[i];
                end
                led[i] <= ({1'b0, pcnt} < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_fade.sv
// tb/tb_pwm_multi_fade.sv - self-checking bench for pwm_multi_fade
module tb_pwm_multi_fade;
    localparam int SYS      = 4000;
    localparam int DEB_MSEC = 1;
    localparam int SCALE    = 16;
    localparam int DIV      = 2;
    localparam int CH       = 4;
    localparam int D        = SYS / 1000 * DEB_MSEC;

    logic          clk   = 1'b0;
    logic          n_rst = 1'b0;
    logic          sw_in = 1'b1;
    logic [CH-1:0] led;
    logic [1:0]    mode;

    pwm_multi_fade #(
        .SYS_CLOCK_FREQ(SYS),
        .CH(CH),
        .SCALE(SCALE),
        .DIV(DIV),
        .DEB_MSEC(DEB_MSEC)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .sw_in(sw_in),
        .led(led),
        .mode(mode)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: n = edges since reset release, origin = edge of
    // the last mode change (fade phase restarts there).
    int            n;
    int            origin;
    int            m_mode;
    int            m_duty [CH];
    logic          m_stable;
    logic          m_hist [$];
    logic [CH-1:0] m_led;
    int            hi [CH];
    int            seq [4];

    typedef struct {
        logic  sw;
        int    cycles;
        int    exp_mode;
        string name;
    } vec_t;
    vec_t vt [6];

    function automatic int tri_f(input int p);
        return (p < SCALE) ? p : 2 * SCALE - 1 - p;
    endfunction

    function automatic int shape_f(input int t);
`ifdef PWM_FADE_GAMMA_EN
        return t * t / SCALE;
`else
        return t;
`endif
    endfunction

    function automatic int duty_of(input int md, input int ph, input int c);
        case (md)
            0:       return 0;
            1:       return SCALE;
            2:       return shape_f(tri_f(ph));
            default: return shape_f(tri_f((ph + c * 2 * SCALE / CH) % (2 * SCALE)));
        endcase
    endfunction

    task automatic model_reset();
        n        = 0;
        origin   = 0;
        m_mode   = 0;
        m_stable = 1'b1;
        m_led    = '0;
        for (int i = 0; i < CH; i++) m_duty[i] = 0;
        m_hist.delete();
        for (int i = 0; i <= D; i++) m_hist.push_back(1'b1);
    endtask

    // One rising edge. m_hist holds raw samples of edges n-D-1 .. n-1; the
    // synchronised level seen at edge e is the raw sample of edge e-2.
    task automatic model_edge();
        int ph;
        bit all_diff;
        n++;
        for (int i = 0; i < CH; i++) m_led[i] = (((n - 1) % SCALE) < m_duty[i]);
        if (n % SCALE == 0) begin
            ph = ((n - 1 - origin) / DIV) % (2 * SCALE);
            for (int i = 0; i < CH; i++) m_duty[i] = duty_of(m_mode, ph, i);
        end
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_hist[j] == m_stable) all_diff = 1'b0;
        if (all_diff) begin
            if (m_stable) begin
                m_mode = (m_mode + 1) % 4;
                origin = n;
            end
            m_stable = ~m_stable;
        end
        m_hist.push_back(sw_in);
        void'(m_hist.pop_front());
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!n_rst) model_reset();
        else model_edge();
        #1;
        check("model_led", 32'(led), 32'(m_led));
        check("model_mode", 32'(mode), 32'(m_mode));
    endtask

    task automatic wait_boundary();
        do tick(); while (n % SCALE != 0);
    endtask

    task automatic measure();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        repeat (SCALE) begin
            tick();
            for (int i = 0; i < CH; i++) hi[i] += int'(led[i]);
        end
    endtask

    task automatic press();
        sw_in = 1'b0;
        repeat (10) tick();
        sw_in = 1'b1;
        repeat (10) tick();
    endtask

    // Times the press so the mode change lands on edge SCALE-1 (mod SCALE):
    // the boundary right after it loads phase 0, later ones phase 8, 16, 24.
    task automatic press_aligned();
        while (n % SCALE != SCALE - 3 - D) tick();
        press();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef PWM_FADE_GAMMA_EN
        seq = '{0, 4, 14, 3};
`else
        seq = '{0, 8, 15, 7};
`endif
        vt[0] = '{sw: 1'b0, cycles: 3,  exp_mode: 0, name: "glitch_3"};
        vt[1] = '{sw: 1'b1, cycles: 12, exp_mode: 0, name: "idle_a"};
        vt[2] = '{sw: 1'b0, cycles: 1,  exp_mode: 0, name: "glitch_1"};
        vt[3] = '{sw: 1'b1, cycles: 1,  exp_mode: 0, name: "gap_1"};
        vt[4] = '{sw: 1'b0, cycles: 3,  exp_mode: 0, name: "glitch_3b"};
        vt[5] = '{sw: 1'b1, cycles: 12, exp_mode: 0, name: "idle_b"};

        model_reset();
        n_rst = 1'b0;
        sw_in = 1'b1;
        repeat (3) tick();
        n_rst = 1'b1;
        check("reset_led", 32'(led), 32'h0);
        check("reset_mode", 32'(mode), 32'h0);
        repeat (64) begin
            tick();
            check("idle_led", 32'(led), 32'h0);
        end

        for (int k = 0; k < 6; k++) begin
            sw_in = vt[k].sw;
            repeat (vt[k].cycles) tick();
            check(vt[k].name, 32'(mode), 32'(vt[k].exp_mode));
        end

        sw_in = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check("press_latency", 32'(mode), (t >= 6) ? 32'd1 : 32'd0);
        end
        sw_in = 1'b1;
        repeat (10) tick();
        wait_boundary();
        repeat (SCALE) begin
            tick();
            check("on_led", 32'(led), 32'hF);
        end

        press_aligned();
        check("breathe_mode", 32'(mode), 32'd2);
        wait_boundary();
        for (int p = 0; p < 8; p++) begin
            measure();
            check("breathe_high", 32'(hi[0]), 32'(seq[(p + 1) % 4]));
        end

        press_aligned();
        check("chase_mode", 32'(mode), 32'd3);
        wait_boundary();
        for (int j = 1; j <= 4; j++) begin
            measure();
            for (int c = 0; c < CH; c++) check("chase_high", 32'(hi[c]), 32'(seq[(j + c) % 4]));
        end

        press();
        check("wrap_mode", 32'(mode), 32'd0);
        wait_boundary();
        repeat (SCALE) begin
            tick();
            check("off_led", 32'(led), 32'h0);
        end

        for (int k = 1; k <= 3; k++) begin
            press();
            check("re_press_mode", 32'(mode), 32'(k));
        end
        repeat (21) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h0);
        check("async_rst_mode", 32'(mode), 32'h0);
        repeat (2) tick();
        n_rst = 1'b1;

        for (int b = 0; b < 300; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                n_rst = 1'b0;
                repeat (2) tick();
                n_rst = 1'b1;
            end
            sw_in = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 12)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
